// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_t;

  localparam int unsigned VEND_DEFAULT_N_PROD   = 4;
  localparam int unsigned VEND_DEFAULT_CREDIT_W = 8;

  // Entry i sits at bits [i*8 +: 8]: idx0=1, idx1=2, idx2=3, idx3=5.
  localparam logic [VEND_DEFAULT_N_PROD*VEND_DEFAULT_CREDIT_W-1:0] VEND_DEFAULT_PRICES =
    {8'd5, 8'd3, 8'd2, 8'd1};

endpackage

// File: rtl/vend_price_lut.sv
// Combinational product-index to price lookup with out-of-range flag.
module vend_price_lut #(
  parameter int unsigned N_PROD   = 4,
  parameter int unsigned CREDIT_W = 8,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = '0,
  localparam int unsigned SEL_W   = $clog2(N_PROD)
) (
  input  logic [SEL_W-1:0]    idx,
  output logic [CREDIT_W-1:0] price,
  output logic                out_of_range
);

  // Indices with no table entry fall through as out of range with a zero price.
  always_comb begin
    price        = '0;
    out_of_range = 1'b1;
    for (int i = 0; i < N_PROD; i++) begin
      if (idx == SEL_W'(i)) begin
        price        = PRICES[i*CREDIT_W +: CREDIT_W];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vend_change_fsm.sv
// Vending controller: credit accumulation, vend handshake and unit-per-cycle change payout.
module vend_change_fsm
  import vend_pkg::*;
#(
  parameter int unsigned N_PROD     = VEND_DEFAULT_N_PROD,
  parameter int unsigned CREDIT_W   = VEND_DEFAULT_CREDIT_W,
  parameter int unsigned MAX_CREDIT = 200,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = VEND_DEFAULT_PRICES,
  localparam int unsigned SEL_W     = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_idx,
  input  logic                cancel,
  input  logic                vend_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_idx,
  output logic [CREDIT_W-1:0] cambio,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                err_sel,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  vend_state_t         state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt, cambio_nxt;
  logic [SEL_W-1:0]    vend_idx_nxt;
  logic                vend_valid_nxt;
  logic                coin_reject_nxt, err_funds_nxt, err_sel_nxt;

  logic [CREDIT_W-1:0] sel_price;
  logic                sel_oor;
  logic [SUM_W-1:0]    coin_sum;

  vend_price_lut #(
    .N_PROD   (N_PROD),
    .CREDIT_W (CREDIT_W),
    .PRICES   (PRICES)
  ) u_price_lut (
    .idx          (sel_idx),
    .price        (sel_price),
    .out_of_range (sel_oor)
  );

  // Extra bit keeps the overflow test exact near the top of the credit range.
  assign coin_sum = {1'b0, credit} + {1'b0, coin_value};

  assign change_pulse = (state == CHANGE);
  assign busy         = (state == DISPENSE) || (state == CHANGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      credit      <= '0;
      cambio      <= '0;
      vend_valid  <= 1'b0;
      vend_idx    <= '0;
      coin_reject <= 1'b0;
      err_funds   <= 1'b0;
      err_sel     <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      cambio      <= cambio_nxt;
      vend_valid  <= vend_valid_nxt;
      vend_idx    <= vend_idx_nxt;
      coin_reject <= coin_reject_nxt;
      err_funds   <= err_funds_nxt;
      err_sel     <= err_sel_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit;
    cambio_nxt      = cambio;
    vend_valid_nxt  = vend_valid;
    vend_idx_nxt    = vend_idx;
    coin_reject_nxt = 1'b0;
    err_funds_nxt   = 1'b0;
    err_sel_nxt     = 1'b0;

    unique case (state)
      IDLE, CREDIT: begin
        // cancel > selection > coin; a coin losing arbitration is handed back.
        if (cancel) begin
          coin_reject_nxt = coin_valid;
          if (credit != '0) begin
            cambio_nxt = credit;
            credit_nxt = '0;
            state_nxt  = CHANGE;
          end
        end else if (sel_valid) begin
          coin_reject_nxt = coin_valid;
          if (sel_oor) begin
            err_sel_nxt = 1'b1;
          end else if (credit < sel_price) begin
            err_funds_nxt = 1'b1;
          end else begin
            cambio_nxt     = credit - sel_price;
            credit_nxt     = '0;
            vend_idx_nxt   = sel_idx;
            vend_valid_nxt = 1'b1;
            state_nxt      = DISPENSE;
          end
        end else if (coin_valid) begin
          if (coin_sum <= SUM_W'(MAX_CREDIT)) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            // A zero-value coin into empty credit leaves the machine idle.
            state_nxt  = (coin_sum == '0) ? IDLE : CREDIT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end

      DISPENSE: begin
        coin_reject_nxt = coin_valid;
        if (vend_ready) begin
          vend_valid_nxt = 1'b0;
          state_nxt      = (cambio != '0) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        coin_reject_nxt = coin_valid;
        cambio_nxt      = cambio - CREDIT_W'(1);
        if (cambio == CREDIT_W'(1)) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
